// File: rtl/ifetch_ctrl.sv
// Fetch/branch-resolve front end: reads the ROM word at pc, resolves BRZ/JMP/HLT
// back into the pc block and emits valid instructions. Optional counters: IFETCH_PERF_EN.
module ifetch_ctrl #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               cond,
  input  logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               halt,
  output logic               branch,
  output logic               jump,
  output logic [PC_W-1:0]    br_off,
  output logic [PC_W-1:0]    jmp_off,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  output logic               halted
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_instr_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH, S_HALTED} state_t;

  localparam logic [3:0] OP_BRZ = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  // The pc block adds the offset to A+1, so the target A+1+off needs off-1.
  function automatic logic [PC_W-1:0] off_to_pc(input logic signed [31:0] off);
    logic signed [31:0] t;
    t = off - 32'sd1;
    return t[PC_W-1:0];
  endfunction

  state_t               state_q, state_d;
  logic [PC_W-1:0]      fpc_q, fpc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]      instr_pc_q, instr_pc_d;
  logic                 instr_valid_q, instr_valid_d;

  logic [3:0]           opcode;
  logic                 is_brz, is_jmp, is_hlt;
  logic                 consume;
  logic signed [31:0]   br_sx, jmp_sx;

  assign opcode    = imem_rdata[15:12];
  assign is_brz    = (opcode == OP_BRZ);
  assign is_jmp    = (opcode == OP_JMP);
  assign is_hlt    = (opcode == OP_HLT);
  assign br_sx     = {{24{imem_rdata[7]}}, imem_rdata[7:0]};
  assign jmp_sx    = {{20{imem_rdata[11]}}, imem_rdata[11:0]};
  assign br_off    = off_to_pc(br_sx);
  assign jmp_off   = off_to_pc(jmp_sx);
  assign imem_addr = pc;

  always_comb begin
    state_d = state_q;
    imem_en = 1'b0;
    halt    = 1'b1;
    branch  = 1'b0;
    jump    = 1'b0;
    consume = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_FILL, S_FLUSH: begin
          imem_en = 1'b1;
          halt    = 1'b0;
          state_d = S_RUN;
        end
        S_RUN: begin
          // Stalled: pc and ROM output freeze so the same word is retried.
          if (!stall) begin
            imem_en = 1'b1;
            consume = 1'b1;
            halt    = is_hlt;
            branch  = is_brz && cond;
            jump    = is_jmp;
            if (branch || jump) state_d = S_FLUSH;
            else if (is_hlt)    state_d = S_HALTED;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fpc_d         = imem_en ? pc : fpc_q;
    instr_d       = consume ? imem_rdata : instr_q;
    instr_pc_d    = consume ? fpc_q : instr_pc_q;
    instr_valid_d = consume;
  end

  // Fetch stage / output stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FILL;
      fpc_q         <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fpc_q         <= fpc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = (state_q == S_HALTED);

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_instr_cnt_q, perf_instr_cnt_d;
  logic [15:0] perf_flush_cnt_q, perf_flush_cnt_d;

  always_comb begin
    perf_instr_cnt_d = perf_instr_cnt_q;
    perf_flush_cnt_d = perf_flush_cnt_q;
    if (instr_valid_q && !(&perf_instr_cnt_q))
      perf_instr_cnt_d = perf_instr_cnt_q + 32'd1;
    if ((state_q == S_FLUSH) && !(&perf_flush_cnt_q))
      perf_flush_cnt_d = perf_flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_instr_cnt_q <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_instr_cnt_q <= perf_instr_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_instr_cnt = perf_instr_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: models the pc block and ROM around the DUT, runs directed
// scenarios and a randomized program checked against an architectural instruction trace.
module tb_ifetch_ctrl;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               stall = 1'b0;
  logic               cond;
  logic               cond_drv = 1'b0;
  logic               use_tab = 1'b0;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    imem_addr, br_off, jmp_off, instr_pc;
  logic [PC_W-1:0]    rd_addr = '0;
  logic               imem_en, halt, branch, jump, instr_valid, halted;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic [INSTR_W-1:0] instr;
`ifdef IFETCH_PERF_EN
  logic [31:0]        perf_instr_cnt;
  logic [15:0]        perf_flush_cnt;
`endif

  logic [15:0] rom [0:1023];
  logic        cond_tab [0:1023];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  ifetch_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .cond(cond), .pc(pc),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .halt(halt), .branch(branch), .jump(jump), .br_off(br_off), .jmp_off(jmp_off),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted)
`ifdef IFETCH_PERF_EN
    ,
    .perf_instr_cnt(perf_instr_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // pc block model: pc+1, or pc+1+offset on a transfer, held while halt is high
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (!halt) begin
      if (branch)    pc <= pc + 10'd1 + br_off;
      else if (jump) pc <= pc + 10'd1 + jmp_off;
      else           pc <= pc + 10'd1;
    end
  end

  // synchronous ROM, holds output while disabled
  always @(posedge clk) begin
    if (imem_en) begin
      imem_rdata <= rom[imem_addr];
      rd_addr    <= imem_addr;
    end
  end

  assign cond = use_tab ? cond_tab[rd_addr] : cond_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    stall = 1'b0;
    @(posedge clk);
    #3;
    check("rst_halt", halt, 1);
    check("rst_imem_en", imem_en, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic rom_nops();
    for (int i = 0; i < 1024; i++) rom[i] = 16'h1000 | 16'(i);
  endtask

  int exp_pc [0:399];
  logic [15:0] exp_w [0:399];

  initial begin
    int cnt, bad, n, idx, p, off;
    logic ended_hlt;
    logic [15:0] w;
    logic signed [7:0] b8;
    logic signed [11:0] j12;

    // straight line then taken branch, followed by reset during FLUSH
    rom_nops();
    rom[4]   = 16'hC0FE;
    cond_drv = 1'b1;
    do_reset();
    #3;
    check("fill_en", imem_en, 1);
    check("fill_halt", halt, 0);
    check("fill_valid", instr_valid, 0);
    for (int c = 1; c <= 4; c++) begin
      goto(c);
      #3;
      check("line_halt", halt, 0);
      if (c >= 2) begin
        check("line_valid", instr_valid, 1);
        check("line_pc", instr_pc, c - 2);
      end
    end
    goto(5);
    #3;
    check("line_pc3", instr_pc, 3);
    check("brz_taken", branch, 1);
    check("brz_off", br_off, 10'h3FD);
    goto(6);
    #3;
    check("brz_retire", instr_pc, 4);
    check("flush_branch", branch, 0);
    goto(7);
    #3;
    check("squash", instr_valid, 0);
    goto(8);
    #3;
    check("brz_target_valid", instr_valid, 1);
    check("brz_target_pc", instr_pc, 3);
    goto(9);
    rst = 1'b1;
    #3;
    check("rflush_valid", instr_valid, 0);
    check("rflush_halt", halt, 1);
    check("rflush_en", imem_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    #3;
    check("rflush_fill_pc", pc, 0);
    check("rflush_fill_en", imem_en, 1);
    check("rflush_fill_valid", instr_valid, 0);
    goto(2);
    #3;
    check("rflush_resume_valid", instr_valid, 1);
    check("rflush_resume_pc", instr_pc, 0);

    // branch not taken
    cond_drv = 1'b0;
    do_reset();
    goto(5);
    #3;
    check("brz_nt", branch, 0);
    goto(7);
    #3;
    check("brz_nt_valid", instr_valid, 1);
    check("brz_nt_pc", instr_pc, 5);

    // jump with wrap to address 0
    rom_nops();
    rom[10] = 16'hDFF5;
    do_reset();
    goto(11);
    #3;
    check("jmp_taken", jump, 1);
    check("jmp_excl", branch, 0);
    check("jmp_off", jmp_off, 10'h3F4);
    goto(12);
    #3;
    check("jmp_retire", instr_pc, 10);
    check("jmp_wrap_pc", pc, 0);
    goto(13);
    #3;
    check("jmp_squash", instr_valid, 0);
`ifdef IFETCH_PERF_EN
    check("perf_flush", perf_flush_cnt, 1);
    check("perf_instr", perf_instr_cnt, 11);
`endif
    goto(14);
    #3;
    check("jmp_target", instr_pc, 0);

    // stall while the JMP word is presented
    do_reset();
    for (int c = 11; c <= 13; c++) begin
      goto(c);
      if (c == 11) stall = 1'b1;
      #3;
      check("stall_halt", halt, 1);
      check("stall_en", imem_en, 0);
      check("stall_jump", jump, 0);
      if (c > 11) check("stall_valid", instr_valid, 0);
    end
    goto(14);
    stall = 1'b0;
    #3;
    check("stall_release_jump", jump, 1);
    cnt = 0;
    for (int c = 15; c <= 20; c++) begin
      goto(c);
      #3;
      if (c == 15) check("stall_jump_once", jump, 0);
      if (instr_valid && instr_pc == 10) cnt++;
    end
    check("stall_jmp_emit_once", cnt, 1);

    // HLT at address 7
    rom_nops();
    rom[7] = 16'hF000;
    do_reset();
    goto(8);
    #3;
    check("hlt_halt", halt, 1);
    check("hlt_not_halted_yet", halted, 0);
    goto(9);
    #3;
    check("hlt_valid", instr_valid, 1);
    check("hlt_pc", instr_pc, 7);
    check("hlt_halted", halted, 1);
    bad = 0;
    for (int c = 10; c < 30; c++) begin
      goto(c);
      #3;
      if (imem_en !== 1'b0 || pc !== 10'd8 || instr_valid !== 1'b0 || halted !== 1'b1) bad++;
    end
    check("hlt_hold", bad, 0);

    // randomized program against an architectural trace
    for (int i = 0; i < 1024; i++) begin
      int r, op;
      w  = 16'($urandom);
      r  = $urandom_range(99);
      if (r < 20)      op = 12;
      else if (r < 28) op = 13;
      else if (r < 30) op = 15;
      else begin
        op = $urandom_range(12);
        if (op == 12) op = 14;
      end
      w[15:12]    = 4'(op);
      rom[i]      = w;
      cond_tab[i] = 1'($urandom_range(1));
    end
    p = 0;
    n = 0;
    ended_hlt = 1'b0;
    while (n < 300 && !ended_hlt) begin
      w = rom[p];
      exp_pc[n] = p;
      exp_w[n]  = w;
      n++;
      b8  = w[7:0];
      j12 = w[11:0];
      off = 0;
      if (w[15:12] == 4'hF) ended_hlt = 1'b1;
      else if (w[15:12] == 4'hC && cond_tab[p]) off = b8;
      else if (w[15:12] == 4'hD) off = j12;
      p = (p + 1 + off) & 1023;
    end
    use_tab = 1'b1;
    do_reset();
    idx = 0;
    for (int c = 1; c < 6000 && idx < n; c++) begin
      goto(c);
      stall = ($urandom_range(3) == 0);
      #3;
      check("rand_excl", branch & jump, 0);
      if (stall) check("rand_stall_xfer", branch | jump, 0);
      if (instr_valid) begin
        check("rand_pc", instr_pc, exp_pc[idx]);
        check("rand_word", instr, exp_w[idx]);
        idx++;
        if (ended_hlt && idx == n) check("rand_halted", halted, 1);
      end
    end
    stall = 1'b0;
    check("rand_done", idx, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Fetch/branch-resolve front end: the consumer end of the program counter interface.
- Reads the instruction word addressed by `pc` from a synchronous instruction ROM (1-cycle latency) and decodes control-flow opcodes.
- Drives `halt`, `branch`, `jump`, `br_off` and `jmp_off` back into the pc block, squashes the one wrong-path word after a taken transfer, and hands valid instructions to decode.

Parameters:
- PC_W, 10, program counter / instruction address width.
- INSTR_W, 16, instruction word width (min 16).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  decode back-pressure; freezes fetch while high (RUN state only).
- cond  in  1  branch condition flag from ALU/flags.
- pc  in  PC_W  current pc from the pc block.
- imem_addr  out  PC_W  ROM address; equals `pc` combinationally.
- imem_en  out  1  ROM read enable; ROM holds its output when 0.
- imem_rdata  in  INSTR_W  ROM data: word at the address presented on the previous enabled cycle.
- halt  out  1  to pc block: hold pc.
- branch  out  1  to pc block: take branch.
- jump  out  1  to pc block: take jump.
- br_off  out  PC_W  branch offset to pc block.
- jmp_off  out  PC_W  jump offset to pc block.
- instr  out  INSTR_W  registered instruction to decode.
- instr_pc  out  PC_W  address of `instr`.
- instr_valid  out  1  `instr` is valid this cycle (one-cycle pulse per instruction).
- halted  out  1  HLT has retired.

Behaviour:
- Opcode is `imem_rdata[15:12]`:
  - BRZ = 4'hC: taken iff `cond`=1; offset is `[7:0]`, sign-extended.
  - JMP = 4'hD: always taken; offset is `[11:0]`, sign-extended.
  - HLT = 4'hF.
  - All other opcodes pass straight through.
- Target = A+1+sext(off), where A is the address of the branch/jump word. The pc block adds the offset to its own pc+1, and its pc is already A+1 when the word arrives. The block therefore outputs `br_off`/`jmp_off` = sext(off) − 1, truncated to PC_W bits (modulo 2^PC_W; wrap-around is allowed).
- Internal register `fpc` holds the address of the word currently on `imem_rdata`. It is loaded with `pc` on every cycle where `imem_en`=1.
- FSM states:
  - FILL: entered on reset, lasts one cycle, word invalid; → RUN.
  - RUN: word valid.
    - Taken BRZ/JMP with `stall`=0 → FLUSH.
    - HLT with `stall`=0 → HALTED.
    - Otherwise stays in RUN.
  - FLUSH: one cycle; the wrong-path word (A+1) is discarded, `instr_valid`=0; → RUN.
  - HALTED: absorbing until `rst`. `halt`=1, `imem_en`=0, `halted`=1.
- RUN with `stall`=1:
  - `halt`=1 and `imem_en`=0, so pc and ROM output are frozen.
  - `branch`, `jump` and `instr_valid` stay 0; the word is not consumed.
  - It is processed on the first cycle with `stall`=0.
- `branch`, `jump` and the offsets are combinational from `imem_rdata`, `cond`, state and `stall`. They are asserted only in RUN with `stall`=0. `branch` and `jump` are never both 1.
- HLT cycle: `halt`=1 combinationally in that cycle, so pc stays at A+1.
- Output stage: `instr`, `instr_pc` ← word and `fpc`, registered one cycle after the word is consumed.
  - `instr_valid`=1 for each consumed word, including BRZ, JMP and HLT.
  - `instr_valid`=0 for FILL and FLUSH words.
- `stall` is ignored in FILL and FLUSH: `halt`=0, `imem_en`=1.
- Reset values: state=FILL, `fpc`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `halted`=0.
  - While `rst`=1: `halt`=1, `branch`=0, `jump`=0, `imem_en`=0.
  - Reset asserted mid-operation aborts any pending flush or stall immediately.
- Latency: ROM word at address A → `instr_valid` at fetch + 2 cycles, absent stall.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- When defined, adds two output ports:
  - `perf_instr_cnt[31:0]`: +1 per `instr_valid` pulse.
  - `perf_flush_cnt[15:0]`: +1 per FLUSH cycle.
  - Both reset to 0 and saturate at all-ones.
- When undefined, neither the ports nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Straight line: ROM[0..3] = 4'h1 opcodes, no stall → `instr_valid` pulses at cycles 2, 3, 4, 5 with `instr_pc` = 0, 1, 2, 3; `halt`=0 throughout.
- Taken branch: ROM[4] = C_xFE (off −2), `cond`=1 → `br_off`=10'h3FD in the cycle the word arrives; the next word is squashed; next `instr_pc`=3. Repeat with `cond`=0 → no flush, next `instr_pc`=5.
- Jump wrap: ROM[10] = D_FF5 (off −11) → `jmp_off`=10'h3F4; target wraps to 0; `perf_flush_cnt`=1 when IFETCH_PERF_EN is defined.
- Stall: assert `stall` for 3 cycles while a JMP word is on `imem_rdata` → `halt`=1, `imem_en`=0, `jump`=0 for 3 cycles; on release `jump`=1 for exactly one cycle; the JMP is emitted once.
- HLT at ROM[7] → `halt`=1 in its arrival cycle; `instr_valid` once with `instr_pc`=7; then `halted`=1, and `imem_en`=0 and pc frozen at 8 for 20 cycles.
- Reset mid-flush: assert `rst` during FLUSH → `instr_valid`=0, `halt`=1 immediately; after release, a FILL cycle, then fetch resumes from pc 0.
